// File: rtl/control.sv
// MIPS control decoder: extracts register addresses and immediates from an
// instruction word and derives ALU/write/jump/branch controls with zero latency.
// The control flags are held inactive while reset is active and for the cycle
// that follows it.

package control_pkg;
    // ALU B-operand select encodings
    localparam logic [1:0] ALU_SRC_REG        = 2'd0;
    localparam logic [1:0] ALU_SRC_SEXT_IMM16 = 2'd1;
    localparam logic [1:0] ALU_SRC_ZEXT_IMM16 = 2'd2;

    // ALU operation encodings
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;
endpackage

module control
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        reg_write,
    output logic [1:0]  alu_src,
    output logic [2:0]  alu_op,
    output logic [4:0]  addr_a,
    output logic [4:0]  addr_b,
    output logic [4:0]  addr_in,
    output logic [4:0]  shamt,
    output logic [15:0] imm16,
    output logic [25:0] addr26,
    output logic        is_jump,
    output logic        is_branch,
    input  logic [31:0] instruction
);

    logic [5:0] op_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic [4:0] rd_s;
    logic [4:0] sh_s;
    logic [5:0] funct_s;

    logic       dec_reg_write_s;
    logic       dec_is_jump_s;
    logic       dec_is_branch_s;
    logic       hold_s;
    logic       in_reset_r;

    assign op_s    = instruction[31:26];
    assign rs_s    = instruction[25:21];
    assign rt_s    = instruction[20:16];
    assign rd_s    = instruction[15:11];
    assign sh_s    = instruction[10:6];
    assign funct_s = instruction[5:0];

    // Raw fields are passed through regardless of opcode
    assign imm16  = instruction[15:0];
    assign addr26 = instruction[25:0];

    // Track whether the previous clock edge saw reset asserted
    always_ff @(posedge clk) begin
        if (reset) begin
            in_reset_r <= 1'b1;
        end else begin
            in_reset_r <= 1'b0;
        end
    end

    // Decode opcode/funct into datapath controls; unknown encodings act as NOP
    always_comb begin
        addr_a          = rs_s;
        addr_b          = rt_s;
        addr_in         = rt_s;
        shamt           = 5'd0;
        alu_src         = ALU_SRC_REG;
        alu_op          = OP_ADD;
        dec_reg_write_s = 1'b0;
        dec_is_jump_s   = 1'b0;
        dec_is_branch_s = 1'b0;
        case (op_s)
            6'h00: begin
                addr_in = rd_s;
                case (funct_s)
                    6'h20: begin alu_op = OP_ADD; dec_reg_write_s = 1'b1; end
                    6'h22: begin alu_op = OP_SUB; dec_reg_write_s = 1'b1; end
                    6'h24: begin alu_op = OP_AND; dec_reg_write_s = 1'b1; end
                    6'h25: begin alu_op = OP_OR;  dec_reg_write_s = 1'b1; end
                    6'h27: begin alu_op = OP_NOR; dec_reg_write_s = 1'b1; end
                    6'h2A: begin alu_op = OP_SLT; dec_reg_write_s = 1'b1; end
                    6'h00: begin
                        alu_op          = OP_SLL;
                        addr_a          = rt_s;
                        shamt           = sh_s;
                        dec_reg_write_s = 1'b1;
                    end
                    6'h02: begin
                        alu_op          = OP_SRL;
                        addr_a          = rt_s;
                        shamt           = sh_s;
                        dec_reg_write_s = 1'b1;
                    end
                    6'h08: begin dec_is_jump_s = 1'b1; end
                    6'h09: begin dec_is_jump_s = 1'b1; dec_reg_write_s = 1'b1; end
                    default: begin dec_reg_write_s = 1'b0; end
                endcase
            end
            6'h08: begin alu_src = ALU_SRC_SEXT_IMM16; dec_reg_write_s = 1'b1; end
            6'h0C: begin
                alu_op          = OP_AND;
                alu_src         = ALU_SRC_ZEXT_IMM16;
                dec_reg_write_s = 1'b1;
            end
            6'h0D: begin
                alu_op          = OP_OR;
                alu_src         = ALU_SRC_ZEXT_IMM16;
                dec_reg_write_s = 1'b1;
            end
            6'h23: begin alu_src = ALU_SRC_SEXT_IMM16; dec_reg_write_s = 1'b1; end
            6'h2B: begin alu_src = ALU_SRC_SEXT_IMM16; end
            6'h04, 6'h05: begin alu_op = OP_SUB; dec_is_branch_s = 1'b1; end
            6'h02: begin dec_is_jump_s = 1'b1; end
            6'h03: begin
                dec_is_jump_s   = 1'b1;
                dec_reg_write_s = 1'b1;
                addr_in         = 5'd31;
            end
            default: begin dec_reg_write_s = 1'b0; end
        endcase
    end

    // Live reset or the trailing reset cycle masks every side-effecting flag
    assign hold_s    = reset | in_reset_r;
    assign reg_write = dec_reg_write_s & ~hold_s;
    assign is_jump   = dec_is_jump_s   & ~hold_s;
    assign is_branch = dec_is_branch_s & ~hold_s;

endmodule

// File: tb/tb_control.sv
// Directed bench for the control decoder: reset masking, every supported
// opcode/funct, shift-amount handling and unknown-encoding NOP behaviour.

module tb_control;
    import control_pkg::*;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [1:0]  alu_src;
    logic [2:0]  alu_op;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [4:0]  addr_in;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic        is_jump;
    logic        is_branch;
    logic [31:0] instruction;

    int checks = 0;
    int errors = 0;

    control dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .addr_in    (addr_in),
        .shamt      (shamt),
        .imm16      (imm16),
        .addr26     (addr26),
        .is_jump    (is_jump),
        .is_branch  (is_branch),
        .instruction(instruction)
    );

    // Free-running clock, rising edge every 10 time units
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every decoded control output of the current instruction
    task automatic chk_all(input string tag, input logic rw, input logic [1:0] src,
                           input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] win, input logic [4:0] sh,
                           input logic j, input logic br);
        chk({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, rw});
        chk({tag, ".alu_src"},   {30'd0, alu_src},   {30'd0, src});
        chk({tag, ".alu_op"},    {29'd0, alu_op},    {29'd0, op});
        chk({tag, ".addr_a"},    {27'd0, addr_a},    {27'd0, a});
        chk({tag, ".addr_b"},    {27'd0, addr_b},    {27'd0, b});
        chk({tag, ".addr_in"},   {27'd0, addr_in},   {27'd0, win});
        chk({tag, ".shamt"},     {27'd0, shamt},     {27'd0, sh});
        chk({tag, ".is_jump"},   {31'd0, is_jump},   {31'd0, j});
        chk({tag, ".is_branch"}, {31'd0, is_branch}, {31'd0, br});
    endtask

    // Apply an instruction away from the clock edge and let decode settle
    task automatic apply(input logic [31:0] ins);
        @(negedge clk);
        instruction = ins;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        instruction = 32'h2010FEFE;
        @(posedge clk);
        @(negedge clk);
        #1;
        // Reset held across an edge: flags masked, datapath fields still decode
        chk_all("rst_addi", 1'b0, ALU_SRC_SEXT_IMM16, OP_ADD, 5'd0, 5'd16, 5'd16, 5'd0, 1'b0, 1'b0);
        chk("rst_addi.imm16", {16'd0, imm16}, 32'h0000FEFE);

        reset = 1'b0;
        #1;
        chk("rst_tail.reg_write", {31'd0, reg_write}, 32'd0);
        @(negedge clk);
        #1;
        chk_all("addi", 1'b1, ALU_SRC_SEXT_IMM16, OP_ADD, 5'd0, 5'd16, 5'd16, 5'd0, 1'b0, 1'b0);
        chk("addi.imm16", {16'd0, imm16}, 32'h0000FEFE);

        apply(32'h00108400);
        chk_all("sll", 1'b1, ALU_SRC_REG, OP_SLL, 5'd16, 5'd16, 5'd16, 5'd16, 1'b0, 1'b0);
        apply(32'h00004020);
        chk_all("add", 1'b1, ALU_SRC_REG, OP_ADD, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0);
        apply(32'h000047E0);
        chk_all("add_junk_sh", 1'b1, ALU_SRC_REG, OP_ADD, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0);
        apply(32'h000940C2);
        chk_all("srl", 1'b1, ALU_SRC_REG, OP_SRL, 5'd9, 5'd9, 5'd8, 5'd3, 1'b0, 1'b0);
        apply(32'h0111482A);
        chk_all("slt", 1'b1, ALU_SRC_REG, OP_SLT, 5'd8, 5'd17, 5'd9, 5'd0, 1'b0, 1'b0);
        apply(32'h02114024);
        chk_all("and", 1'b1, ALU_SRC_REG, OP_AND, 5'd16, 5'd17, 5'd8, 5'd0, 1'b0, 1'b0);
        apply(32'h01094022);
        chk_all("sub", 1'b1, ALU_SRC_REG, OP_SUB, 5'd8, 5'd9, 5'd8, 5'd0, 1'b0, 1'b0);
        apply(32'h01094025);
        chk_all("or", 1'b1, ALU_SRC_REG, OP_OR, 5'd8, 5'd9, 5'd8, 5'd0, 1'b0, 1'b0);
        apply(32'h01094027);
        chk_all("nor", 1'b1, ALU_SRC_REG, OP_NOR, 5'd8, 5'd9, 5'd8, 5'd0, 1'b0, 1'b0);
        apply(32'h320900CF);
        chk_all("andi", 1'b1, ALU_SRC_ZEXT_IMM16, OP_AND, 5'd16, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
        chk("andi.imm16", {16'd0, imm16}, 32'h000000CF);
        apply(32'h360900C0);
        chk_all("ori", 1'b1, ALU_SRC_ZEXT_IMM16, OP_OR, 5'd16, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
        chk("ori.imm16", {16'd0, imm16}, 32'h000000C0);
        apply(32'h8D280004);
        chk_all("lw", 1'b1, ALU_SRC_SEXT_IMM16, OP_ADD, 5'd9, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
        apply(32'hAD280004);
        chk_all("sw", 1'b0, ALU_SRC_SEXT_IMM16, OP_ADD, 5'd9, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
        apply(32'h1520FFFD);
        chk_all("bne", 1'b0, ALU_SRC_REG, OP_SUB, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        apply(32'h11200003);
        chk_all("beq", 1'b0, ALU_SRC_REG, OP_SUB, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        apply(32'h0C000010);
        chk_all("jal", 1'b1, ALU_SRC_REG, OP_ADD, 5'd0, 5'd0, 5'd31, 5'd0, 1'b1, 1'b0);
        chk("jal.addr26", {6'd0, addr26}, 32'h00000010);
        apply(32'h08000020);
        chk_all("j", 1'b0, ALU_SRC_REG, OP_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        apply(32'h03E00008);
        chk_all("jr", 1'b0, ALU_SRC_REG, OP_ADD, 5'd31, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        apply(32'h0120F809);
        chk_all("jalr", 1'b1, ALU_SRC_REG, OP_ADD, 5'd9, 5'd0, 5'd31, 5'd0, 1'b1, 1'b0);
        apply(32'hFD2847E0);
        chk_all("bad_op", 1'b0, ALU_SRC_REG, OP_ADD, 5'd9, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
        apply(32'h0109403F);
        chk_all("bad_funct", 1'b0, ALU_SRC_REG, OP_ADD, 5'd8, 5'd9, 5'd8, 5'd0, 1'b0, 1'b0);

        // Mid-stream reset masks flags in the same cycle, before any edge
        apply(32'h0C000010);
        reset = 1'b1;
        #1;
        chk_all("mid_rst_jal", 1'b0, ALU_SRC_REG, OP_ADD, 5'd0, 5'd0, 5'd31, 5'd0, 1'b0, 1'b0);
        apply(32'h1520FFFD);
        chk("mid_rst_bne.is_branch", {31'd0, is_branch}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_tail.is_branch", {31'd0, is_branch}, 32'd0);
        @(negedge clk);
        #1;
        chk("rel_done.is_branch", {31'd0, is_branch}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
